// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hold, flush, redirect, bus/halt drain.
// Optional stall counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_hold_i,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_busy_i,
    input  logic        bus_req_i,
    input  logic        jtag_halt_i,
    output logic [2:0]  hold_flag_o,
    output logic        flush_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_grant_o,
    output logic        halt_ack_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_ID   = 3'b011;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        BUS_GNT = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t     state, state_d;
    logic       ret_halt, ret_halt_d;
    logic [3:0] flush_cnt;
    logic       jump_acc;

    // State and return-target registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ret_halt <= 1'b0;
        end else begin
            state    <= state_d;
            ret_halt <= ret_halt_d;
        end
    end

    // Next-state: bus request wins over halt; drain waits on memory port
    always_comb begin
        state_d    = state;
        ret_halt_d = ret_halt;
        case (state)
            RUN: begin
                if (bus_req_i || jtag_halt_i)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (!mem_busy_i) begin
                    if (bus_req_i) begin
                        state_d    = BUS_GNT;
                        ret_halt_d = 1'b0;
                    end else if (jtag_halt_i) begin
                        state_d = HALTED;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            BUS_GNT: begin
                if (!bus_req_i)
                    state_d = (ret_halt && jtag_halt_i) ? HALTED : RUN;
            end
            HALTED: begin
                if (bus_req_i) begin
                    state_d    = BUS_GNT;
                    ret_halt_d = 1'b1;
                end else if (!jtag_halt_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Jumps are only honoured while the core still owns the pipeline
    always_comb begin
        jump_acc    = jump_req_i && (state == RUN || state == DRAIN);
        jump_flag_o = jump_acc;
        jump_addr_o = jump_acc ? jump_addr_i : 32'h0;
    end

    // Flush stretch counter; a new jump reloads it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_cnt <= 4'd0;
        else if (jump_acc)
            flush_cnt <= FLUSH_LOAD;
        else if (flush_cnt != 4'd0)
            flush_cnt <= flush_cnt - 4'd1;
    end

    // State-decoded hold, grant and ack outputs
    always_comb begin
        hold_flag_o = HOLD_ID;
        if (state == RUN)
            hold_flag_o = ex_hold_i ? HOLD_ID : HOLD_NONE;
        flush_o     = jump_acc || (flush_cnt != 4'd0);
        bus_grant_o = (state == BUS_GNT);
        halt_ack_o  = (state == HALTED);
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;

    // Count every cycle the pipeline is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 32'h0;
        else if (hold_flag_o != HOLD_NONE)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles_o = stall_cnt;
`else
    assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_hold_i = 1'b0;
    logic        jump_req_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        mem_busy_i = 1'b0;
    logic        bus_req_i = 1'b0;
    logic        jtag_halt_i = 1'b0;
    logic [2:0]  hold_flag_o;
    logic        flush_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        bus_grant_o;
    logic        halt_ack_o;
    logic [31:0] stall_cycles_o;

    int checks = 0;
    int passes = 0;

    pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .ex_hold_i(ex_hold_i),
        .jump_req_i(jump_req_i),
        .jump_addr_i(jump_addr_i),
        .mem_busy_i(mem_busy_i),
        .bus_req_i(bus_req_i),
        .jtag_halt_i(jtag_halt_i),
        .hold_flag_o(hold_flag_o),
        .flush_o(flush_o),
        .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o),
        .bus_grant_o(bus_grant_o),
        .halt_ack_o(halt_ack_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({hold_flag_o, flush_o, jump_flag_o, bus_grant_o, halt_ack_o}
            !== 7'b0 || jump_addr_o !== 32'h0 || stall_cycles_o !== 32'h0)
            $display("FAIL reset_outputs got hold=%0d fl=%0b jf=%0b ja=%0h gnt=%0b ack=%0b st=%0d exp all 0",
                     hold_flag_o, flush_o, jump_flag_o, jump_addr_o,
                     bus_grant_o, halt_ack_o, stall_cycles_o);
        else passes++;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if (hold_flag_o !== 3'b000 || bus_grant_o !== 1'b0 || flush_o !== 1'b0)
            $display("FAIL reset_release got hold=%0d gnt=%0b fl=%0b exp 0",
                     hold_flag_o, bus_grant_o, flush_o);
        else passes++;
        cyc();
    endtask

    task automatic test_ex_hold();
        logic [2:0] exp;
        for (int c = 0; c < 7; c++) begin
            ex_hold_i = (c >= 1 && c <= 5);
            exp = (c >= 1 && c <= 5) ? 3'b011 : 3'b000;
            @(negedge clk);
            checks++;
            if (hold_flag_o !== exp)
                $display("FAIL ex_hold c%0d got %0d exp %0d", c, hold_flag_o, exp);
            else passes++;
            cyc();
        end
        ex_hold_i = 1'b0;
    endtask

    task automatic test_jump();
        logic exp_fl;
        logic exp_jf;
        for (int c = 0; c < 8; c++) begin
            // single jump at c0, back-to-back jumps at c4 and c5
            exp_jf = (c == 0 || c == 4 || c == 5);
            exp_fl = (c <= 1) || (c >= 4 && c <= 6);
            jump_req_i  = exp_jf;
            jump_addr_i = exp_jf ? 32'h0000_0100 : 32'h0;
            @(negedge clk);
            checks++;
            if (jump_flag_o !== exp_jf || flush_o !== exp_fl ||
                jump_addr_o !== (exp_jf ? 32'h100 : 32'h0))
                $display("FAIL jump c%0d got jf=%0b fl=%0b ja=%0h exp jf=%0b fl=%0b",
                         c, jump_flag_o, flush_o, jump_addr_o, exp_jf, exp_fl);
            else passes++;
            cyc();
        end
        jump_req_i  = 1'b0;
        jump_addr_i = 32'h0;
    endtask

    task automatic test_bus();
        logic       exp_g;
        logic [2:0] exp_h;
        for (int c = 0; c < 12; c++) begin
            bus_req_i  = (c <= 9);
            mem_busy_i = (c <= 2);
            jump_req_i = (c == 6);
            jump_addr_i = (c == 6) ? 32'h55 : 32'h0;
            exp_g = (c >= 4 && c <= 10);
            exp_h = (c >= 1 && c <= 10) ? 3'b011 : 3'b000;
            @(negedge clk);
            checks++;
            if (bus_grant_o !== exp_g || hold_flag_o !== exp_h)
                $display("FAIL bus c%0d got gnt=%0b hold=%0d exp gnt=%0b hold=%0d",
                         c, bus_grant_o, hold_flag_o, exp_g, exp_h);
            else passes++;
            if (c == 6) begin
                checks++;
                if (jump_flag_o !== 1'b0 || jump_addr_o !== 32'h0 || flush_o !== 1'b0)
                    $display("FAIL jump_in_grant got jf=%0b ja=%0h fl=%0b exp 0",
                             jump_flag_o, jump_addr_o, flush_o);
                else passes++;
            end
            cyc();
        end
        bus_req_i  = 1'b0;
        mem_busy_i = 1'b0;
        jump_req_i = 1'b0;
        jump_addr_i = 32'h0;
    endtask

    task automatic test_halt();
        logic exp_a;
        logic exp_g;
        logic [2:0] exp_h;
        for (int c = 0; c < 9; c++) begin
            jtag_halt_i = (c <= 6);
            bus_req_i   = (c == 3 || c == 4);
            jump_req_i  = (c == 1 || c == 3);
            jump_addr_i = jump_req_i ? 32'h200 : 32'h0;
            exp_a = (c == 2 || c == 3 || c == 6 || c == 7);
            exp_g = (c == 4 || c == 5);
            exp_h = (c >= 1 && c <= 7) ? 3'b011 : 3'b000;
            @(negedge clk);
            checks++;
            if (halt_ack_o !== exp_a || bus_grant_o !== exp_g || hold_flag_o !== exp_h)
                $display("FAIL halt c%0d got ack=%0b gnt=%0b hold=%0d exp ack=%0b gnt=%0b hold=%0d",
                         c, halt_ack_o, bus_grant_o, hold_flag_o, exp_a, exp_g, exp_h);
            else passes++;
            if (c == 1 || c == 3) begin
                checks++;
                if (jump_flag_o !== (c == 1) || jump_addr_o !== ((c == 1) ? 32'h200 : 32'h0))
                    $display("FAIL halt_jump c%0d got jf=%0b ja=%0h exp jf=%0b",
                             c, jump_flag_o, jump_addr_o, (c == 1));
                else passes++;
            end
            cyc();
        end
        jtag_halt_i = 1'b0;
        bus_req_i   = 1'b0;
        jump_req_i  = 1'b0;
        jump_addr_i = 32'h0;
        cyc();
        cyc();
    endtask

    task automatic test_both();
        logic exp_a;
        logic exp_g;
        logic [2:0] exp_h;
        for (int c = 0; c < 8; c++) begin
            bus_req_i   = (c <= 2);
            jtag_halt_i = (c <= 5);
            exp_g = (c == 2 || c == 3);
            exp_a = (c == 6);
            exp_h = (c == 0 || c == 4 || c == 7) ? 3'b000 : 3'b011;
            @(negedge clk);
            checks++;
            if (halt_ack_o !== exp_a || bus_grant_o !== exp_g || hold_flag_o !== exp_h)
                $display("FAIL both c%0d got ack=%0b gnt=%0b hold=%0d exp ack=%0b gnt=%0b hold=%0d",
                         c, halt_ack_o, bus_grant_o, hold_flag_o, exp_a, exp_g, exp_h);
            else passes++;
            cyc();
        end
        bus_req_i   = 1'b0;
        jtag_halt_i = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        bus_req_i = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (bus_grant_o !== 1'b1)
            $display("FAIL pre_reset_grant got %0b exp 1", bus_grant_o);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_grant_o !== 1'b0 || halt_ack_o !== 1'b0 || hold_flag_o !== 3'b000 ||
            flush_o !== 1'b0 || jump_flag_o !== 1'b0 || stall_cycles_o !== 32'h0)
            $display("FAIL async_reset got gnt=%0b ack=%0b hold=%0d fl=%0b st=%0d exp 0",
                     bus_grant_o, halt_ack_o, hold_flag_o, flush_o, stall_cycles_o);
        else passes++;
        bus_req_i = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_perf();
        logic [31:0] exp;
`ifdef PIPE_CTRL_PERF_EN
        exp = 32'd7;
`else
        exp = 32'd0;
`endif
        for (int c = 0; c < 7; c++) begin
            ex_hold_i = 1'b1;
            cyc();
        end
        ex_hold_i = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cycles_o !== exp)
            $display("FAIL stall_count got %0d exp %0d", stall_cycles_o, exp);
        else passes++;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (stall_cycles_o !== exp)
            $display("FAIL stall_hold got %0d exp %0d", stall_cycles_o, exp);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_ex_hold();
        test_jump();
        test_bus();
        test_halt();
        test_both();
        test_async_reset();
        test_perf();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 32-bit RV32I core. It merges the stall and redirect requests from the execute stage, an external bus master and the JTAG debug halt. It drives the hold level consumed by the pc/if_id/id_ex pipeline registers, a stretched flush pulse, and the pc redirect. A drain handshake ensures the core's own memory access completes before bus ownership or halt is handed over.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles flush_o stays high per accepted jump; legal 1..15.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ex_hold_i  input  1  execute multi-cycle op busy (divider)
- jump_req_i  input  1  execute requests pc redirect
- jump_addr_i  input  32  redirect target
- mem_busy_i  input  1  core load/store in flight on memory port
- bus_req_i  input  1  external bus master requests memory port, level
- jtag_halt_i  input  1  debug halt request, level
- hold_flag_o  output  3  Hold_None=3'b000, Hold_Pc=3'b001, Hold_If=3'b010, Hold_Id=3'b011
- flush_o  output  1  replace if_id/id_ex contents with NOP/zero
- jump_flag_o  output  1  pc redirect strobe
- jump_addr_o  output  32  pc redirect target
- bus_grant_o  output  1  external master owns memory port
- halt_ack_o  output  1  core halted and drained
- stall_cycles_o  output  32  stall counter (see Configuration)

## Operation
- FSM states: RUN, DRAIN, BUS_GNT, HALTED. Register ret_halt (1 bit) records the return target from BUS_GNT.
- RUN:
  - bus_req_i=1 -> DRAIN.
  - Else jtag_halt_i=1 -> DRAIN.
  - bus_req_i has priority when both requests are present.
- DRAIN: waits for the core's memory access to finish. With mem_busy_i=0, the next state is:
  - BUS_GNT if bus_req_i=1 (ret_halt=0);
  - else HALTED if jtag_halt_i=1;
  - else RUN (request withdrawn).
- BUS_GNT: bus_req_i=0 -> HALTED if ret_halt and jtag_halt_i, else RUN.
- HALTED:
  - bus_req_i=1 -> BUS_GNT with ret_halt=1.
  - Else jtag_halt_i=0 -> RUN.
- hold_flag_o:
  - Hold_Id in DRAIN, BUS_GNT and HALTED.
  - In RUN: Hold_Id if ex_hold_i, else Hold_None.
- State-decoded outputs: bus_grant_o = (state==BUS_GNT); halt_ack_o = (state==HALTED).
- Jump handling:
  - jump_req_i is accepted in RUN and DRAIN.
  - jump_flag_o = jump_req_i and jump_addr_o = jump_addr_i, combinationally, when accepted.
  - jump_flag_o=0 and jump_addr_o=0 otherwise; the request is ignored in BUS_GNT and HALTED.
- Flush counter (4 bit):
  - An accepted jump loads FLUSH_CYCLES-1.
  - The counter decrements to 0 when nonzero.
  - flush_o = accepted jump OR counter != 0.
  - A jump during an active flush reloads the counter.

## Timing
- Reset values: state RUN, ret_halt 0, counter 0. Outputs: hold_flag_o Hold_None, flush_o 0, jump_flag_o 0, jump_addr_o 0, bus_grant_o 0, halt_ack_o 0, stall_cycles_o 0.
- Hold latency:
  - ex_hold_i to Hold_Id: 0 cycles (combinational).
  - bus_req_i/jtag_halt_i to Hold_Id: 1 cycle (DRAIN).
- Grant latency: a request in cycle N with mem_busy_i=0 in N+1 gives grant in N+2. Each further busy cycle adds one.
- Release: bus_req_i low in cycle M -> bus_grant_o low and hold released (RUN) from M+1. The master stops driving the port in cycle M.
- flush_o spans exactly FLUSH_CYCLES cycles starting with the jump cycle.
- Reset mid-grant or mid-halt drops bus_grant_o and halt_ack_o immediately (asynchronous).

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles_o counts cycles with hold_flag_o != Hold_None.
  - The count is 32-bit, wraps to 0 after 0xFFFFFFFF, and resets to 0.
- Undefined: stall_cycles_o is tied to 32'h0 and no counter logic exists. The port is present in both builds.

## Test plan
- ex_hold_i high for 5 cycles in RUN -> hold_flag_o=3'b011 for exactly those 5 cycles, 0 before and after.
- jump_req_i=1, jump_addr_i=0x0000_0100 for one cycle, FLUSH_CYCLES=2 -> jump_flag_o=1 and jump_addr_o=0x100 in that cycle; flush_o high for 2 cycles. A second jump in the next cycle extends flush_o to 3 cycles total.
- bus_req_i rises at cycle 10 with mem_busy_i=1 through cycle 12 -> hold from 11, DRAIN 11-13, bus_grant_o=1 from 14. bus_req_i low at 20 -> grant=0 and hold_flag_o=0 at 21.
- jtag_halt_i=1 -> halt_ack_o after drain. bus_req_i during halt -> grant, halt_ack_o=0. Release bus -> halt_ack_o=1 again. Drop halt -> RUN, hold=Hold_None.
- bus_req_i and jtag_halt_i rise together -> BUS_GNT first (ret_halt=0). On release with halt still high -> RUN, then DRAIN, then HALTED.
- Assert rst while in BUS_GNT -> all outputs zero without a clock edge. With PIPE_CTRL_PERF_EN, 7 hold cycles -> stall_cycles_o=7. Without the macro -> stall_cycles_o=0.
